rv32_pc_sequencer: RTL and testbench
====================================

# rv32_pc_sequencer

Parametrised multi-hart program-counter sequencer for the barrel-threaded pito core. It holds one PC per hart, selects a hart every cycle in round-robin order over a runtime enable mask, and emits that hart's fetch PC. It absorbs per-hart redirects from the next-PC stage (taken branch, JAL/JALR, MRET) and per-hart interrupt vectors. It replaces the single-PC "pc+4 unless new PC" update with per-hart state, interrupt deferral and mepc capture.

## Interface
- `NUM_HARTS`, 8: number of harts; power of two, ≥2.
- `PC_W`, 32: PC width.
- `RESET_PC`, 0: reset PC of every hart.
- `HID_W`, $clog2(NUM_HARTS): hart-id width (derived).
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `hart_en`  in  NUM_HARTS  per-hart enable mask; disabled harts are skipped.
- `stall`  in  1  freezes selection, PCs and outputs.
- `redirect_valid`  in  1  apply `redirect_pc` to `redirect_hart`.
- `redirect_hart`  in  HID_W  target hart of redirect.
- `redirect_pc`  in  PC_W  new PC (next-PC stage result).
- `irq_valid`  in  NUM_HARTS  one-cycle interrupt pulse per hart.
- `irq_pc`  in  NUM_HARTS*PC_W  vector per hart, hart h at bits [h*PC_W +: PC_W], sampled with its pulse.
- `fetch_valid`  out  1  fetch slot valid.
- `fetch_hart`  out  HID_W  hart of this slot.
- `fetch_pc`  out  PC_W  PC to fetch.
- `fetch_irq`  out  1  slot is an interrupt entry.
- `irq_epc`  out  PC_W  PC displaced by the interrupt, for mepc write; valid with `fetch_irq`.

## Operation
- State: `pc[NUM_HARTS]`, `ptr` (last selected hart), `irq_pend[NUM_HARTS]`, `irq_vec[NUM_HARTS]`.
- Selection: `sel` is the first enabled hart strictly after `ptr`, searching upward and wrapping to 0. If `ptr` is the only enabled hart, it is selected again. If `hart_en` is 0, there is no selection.
- Effective PC of `sel`: `redirect_pc` if `redirect_valid` and `redirect_hart == sel` (bypass), otherwise `pc[sel]`.
- Normal slot: emit the effective PC, then `pc[sel] <= effPC + 4` (modulo 2^PC_W).
- IRQ slot (`irq_pend[sel]` set):
  - emit `irq_vec[sel]` with `fetch_irq = 1` and `irq_epc = effPC`;
  - `pc[sel] <= irq_vec[sel] + 4`;
  - clear `irq_pend[sel]`.
- Redirect to a hart other than `sel`: `pc[redirect_hart] <= redirect_pc`.
- `irq_valid[h]` sets `irq_pend[h]` and captures `irq_vec[h]`. A repeat pulse while pending overwrites the vector (last wins). A pulse for `sel` in the same cycle is deferred to that hart's next slot.
- Disabled harts keep their PC, pending IRQ and vector; they resume from them when re-enabled.
- `stall` high: no state update except IRQ capture and redirect writes, which are still applied. Outputs hold.

## Timing
- Outputs are registered. Selection made in cycle t appears on the outputs in t+1. Redirect-to-fetch latency is 1 cycle via the bypass.
- Reset values:
  - all `pc` = RESET_PC; `ptr` = NUM_HARTS-1, so hart 0 is first;
  - `irq_pend` = 0, `irq_vec` = 0;
  - all outputs 0.
- First fetch is on the first cycle after `rst` deasserts (hart 0 if enabled).
- `fetch_valid` is 0 in the cycle after a no-selection cycle. The other outputs are don't-care then, but driven 0.
- Reset asserted mid-stream clears all state immediately (asynchronous); pending IRQs are lost.

## Structure
- In `pito_pkg`:
  - `hart_id_t` (HID_W bits);
  - default `NUM_HARTS` constant;
  - `PC_INCR = 4`.
- `rv32_pc_cnt_t` stays in `rv32_pkg`.
- Sub-module `rv32_rr_select`: combinational next-enabled-after-pointer finder (mask, ptr → sel, any). It is reused by the register-file bank selector.

## Test plan
- Reset with `hart_en = 8'hFF`, release: harts 0..7 fetch PC 0, then each hart fetches PC 4 in cycles 9..16.
- `hart_en = 8'b0010_0101`: hart order 0, 2, 5, 0, …; PCs advance by 4 per slot. Clearing bit 2 mid-run skips hart 2 on the next rotation.
- Redirect hart 3 to 0x100 in the cycle hart 3 is selected: `fetch_pc = 0x100`, next hart-3 fetch = 0x104. Redirect to a non-selected hart takes effect on its next slot.
- `irq_valid[1]` with vector 0x80 while hart 1 is at 0x20: hart 1's next slot shows `fetch_irq = 1`, `fetch_pc = 0x80`, `irq_epc = 0x20`, then 0x84.
- Redirect and pending IRQ on the same hart and slot (redirect 0x200, vector 0x80): `fetch_pc = 0x80`, `irq_epc = 0x200`.
- `stall` held 3 cycles: outputs and PCs frozen; an IRQ pulse during the stall is taken at that hart's next slot. `hart_en = 0` gives `fetch_valid = 0`. Async `rst` pulse mid-run gives all outputs 0 and the restart rule of scenario 1.

Source files
------------

// File: rtl/pito_pkg.sv
// pito_pkg: shared constants and types for the barrel-threaded pito core.
//   NUM_HARTS_DEF : default hart count
//   HART_ID_W     : hart-id width for the default hart count
//   PC_INCR       : sequential fetch stride in bytes
//   hart_id_t     : hart identifier for the default configuration
package pito_pkg;

    localparam int NUM_HARTS_DEF = 8;
    localparam int HART_ID_W     = $clog2(NUM_HARTS_DEF);
    localparam int PC_INCR       = 4;

    typedef logic [HART_ID_W-1:0] hart_id_t;

endpackage

// File: rtl/rv32_pc_sequencer_if.sv
// rv32_pc_sequencer_if: control and fetch bundle of the PC sequencer.
//   hart_en, stall                 : issue control
//   redirect_valid/hart/pc         : next-PC stage redirect
//   irq_valid, irq_pc              : per-hart interrupt pulse + vector (hart h at [h*PC_W +: PC_W])
//   fetch_valid/hart/pc/irq, irq_epc : registered fetch slot
// slave = sequencer side, master = core side driving control.
interface rv32_pc_sequencer_if #(
    parameter int NUM_HARTS = pito_pkg::NUM_HARTS_DEF,
    parameter int PC_W      = 32,
    parameter int HID_W     = $clog2(NUM_HARTS)
);
    logic [NUM_HARTS-1:0]      hart_en;
    logic                      stall;
    logic                      redirect_valid;
    logic [HID_W-1:0]          redirect_hart;
    logic [PC_W-1:0]           redirect_pc;
    logic [NUM_HARTS-1:0]      irq_valid;
    logic [NUM_HARTS*PC_W-1:0] irq_pc;
    logic                      fetch_valid;
    logic [HID_W-1:0]          fetch_hart;
    logic [PC_W-1:0]           fetch_pc;
    logic                      fetch_irq;
    logic [PC_W-1:0]           irq_epc;

    modport master (
        output hart_en, stall, redirect_valid, redirect_hart, redirect_pc, irq_valid, irq_pc,
        input  fetch_valid, fetch_hart, fetch_pc, fetch_irq, irq_epc
    );

    modport slave (
        input  hart_en, stall, redirect_valid, redirect_hart, redirect_pc, irq_valid, irq_pc,
        output fetch_valid, fetch_hart, fetch_pc, fetch_irq, irq_epc
    );
endinterface

// File: rtl/rv32_rr_select.sv
// rv32_rr_select: combinational round-robin finder.
//   mask : candidate enable mask
//   ptr  : last granted index
//   sel  : first set bit of mask strictly after ptr, wrapping; ptr itself last
//   any  : mask non-zero
// Shared with the register-file bank selector.
module rv32_rr_select #(
    parameter int N     = 8,
    parameter int HID_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [HID_W-1:0] ptr,
    output logic [HID_W-1:0] sel,
    output logic             any
);
    logic [HID_W-1:0] idx;

    // N is a power of two, so the HID_W-bit add wraps naturally; i == N lands on ptr.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        for (int i = 1; i <= N; i++) begin
            idx = ptr + HID_W'(i);
            if (!any && mask[idx]) begin
                any = 1'b1;
                sel = idx;
            end
        end
    end
endmodule

// File: rtl/rv32_pc_sequencer.sv
// rv32_pc_sequencer: per-hart PC state with round-robin fetch issue.
//   clk, rst : core clock, async active-high reset
//   bus      : rv32_pc_sequencer_if.slave (control in, registered fetch slot out)
// Each cycle picks the next enabled hart after the last one, emits its PC
// (or its pending interrupt vector), and advances that hart's PC by 4.
module rv32_pc_sequencer
    import pito_pkg::*;
#(
    parameter int              NUM_HARTS = NUM_HARTS_DEF,
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              HID_W     = $clog2(NUM_HARTS)
) (
    input logic                clk,
    input logic                rst,
    rv32_pc_sequencer_if.slave bus
);
    logic [NUM_HARTS-1:0][PC_W-1:0] pc;
    logic [NUM_HARTS-1:0][PC_W-1:0] irq_vec;
    logic [NUM_HARTS-1:0]           irq_pend;
    logic [HID_W-1:0]               ptr;

    logic [HID_W-1:0] sel;
    logic             any;
    logic             take_irq;
    logic             advance;
    logic [PC_W-1:0]  eff_pc;
    logic [PC_W-1:0]  slot_pc;

    rv32_rr_select #(.N(NUM_HARTS), .HID_W(HID_W)) u_sel (
        .mask (bus.hart_en),
        .ptr  (ptr),
        .sel  (sel),
        .any  (any)
    );

    // A redirect aimed at the hart being issued bypasses its stored PC.
    always_comb begin
        eff_pc   = (bus.redirect_valid && bus.redirect_hart == sel) ? bus.redirect_pc : pc[sel];
        take_irq = any && irq_pend[sel];
        slot_pc  = take_irq ? irq_vec[sel] : eff_pc;
        advance  = any && !bus.stall;
    end

    // Redirect writes and IRQ capture are applied even while stalled. The slot
    // update comes after the redirect write so it wins for the selected hart;
    // it already carries the bypassed value. IRQ capture comes after the slot's
    // pending clear, so a pulse arriving for the issuing hart stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= {NUM_HARTS{RESET_PC}};
            irq_vec  <= '0;
            irq_pend <= '0;
            ptr      <= HID_W'(NUM_HARTS - 1);
        end else begin
            if (bus.redirect_valid)
                pc[bus.redirect_hart] <= bus.redirect_pc;
            if (advance) begin
                ptr     <= sel;
                pc[sel] <= slot_pc + PC_W'(PC_INCR);
                if (take_irq)
                    irq_pend[sel] <= 1'b0;
            end
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (bus.irq_valid[h]) begin
                    irq_pend[h] <= 1'b1;
                    irq_vec[h]  <= bus.irq_pc[h*PC_W +: PC_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fetch_valid <= 1'b0;
            bus.fetch_hart  <= '0;
            bus.fetch_pc    <= '0;
            bus.fetch_irq   <= 1'b0;
            bus.irq_epc     <= '0;
        end else if (!bus.stall) begin
            bus.fetch_valid <= any;
            bus.fetch_hart  <= any ? sel : '0;
            bus.fetch_pc    <= any ? slot_pc : '0;
            bus.fetch_irq   <= take_irq;
            bus.irq_epc     <= take_irq ? eff_pc : '0;
        end
    end
endmodule

// File: tb/tb_rv32_pc_sequencer.sv
// tb_rv32_pc_sequencer: directed vectors for the PC sequencer, 8 harts, 32-bit PCs.
module tb_rv32_pc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    rv32_pc_sequencer_if #(.NUM_HARTS(8), .PC_W(32)) bus ();

    rv32_pc_sequencer #(.NUM_HARTS(8), .PC_W(32), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string t, input logic v, input int h, input logic [31:0] pc,
                        input logic irq, input logic [31:0] epc);
        chk({t, ".valid"}, 32'(bus.fetch_valid), 32'(v));
        chk({t, ".hart"},  32'(bus.fetch_hart),  32'(h));
        chk({t, ".pc"},    bus.fetch_pc,         pc);
        chk({t, ".irq"},   32'(bus.fetch_irq),   32'(irq));
        chk({t, ".epc"},   bus.irq_epc,          epc);
    endtask

    task automatic slot(input string t, input int h, input logic [31:0] pc,
                        input logic irq = 1'b0, input logic [31:0] epc = 32'h0);
        tick();
        outs(t, 1'b1, h, pc, irq, epc);
    endtask

    task automatic redir(input logic v, input int h, input logic [31:0] pc);
        bus.redirect_valid = v;
        bus.redirect_hart  = 3'(h);
        bus.redirect_pc    = pc;
    endtask

    task automatic irq(input int h, input logic [31:0] vec);
        bus.irq_valid       = '0;
        bus.irq_pc          = '0;
        bus.irq_valid[h]    = 1'b1;
        bus.irq_pc[h*32 +: 32] = vec;
    endtask

    task automatic irq_off();
        bus.irq_valid = '0;
        bus.irq_pc    = '0;
    endtask

    initial begin
        bus.hart_en = '0;
        bus.stall   = 1'b0;
        redir(1'b0, 0, 32'h0);
        irq_off();

        // reset with all harts enabled
        #1 rst = 1'b1;
        bus.hart_en = 8'hFF;
        tick();
        tick();
        outs("rst", 1'b0, 0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) slot("s1a", k, 32'h0);
        for (int k = 0; k < 8; k++) slot("s1b", k, 32'h4);

        // sparse mask, then drop hart 2 mid-run
        bus.hart_en = 8'b0010_0101;
        slot("s2", 0, 32'd8);  slot("s2", 2, 32'd8);  slot("s2", 5, 32'd8);
        slot("s2", 0, 32'd12); slot("s2", 2, 32'd12); slot("s2", 5, 32'd12);
        bus.hart_en = 8'b0010_0001;
        slot("s2x", 0, 32'd16); slot("s2x", 5, 32'd16); slot("s2x", 0, 32'd20);

        // redirect on the selected hart (bypass), then on a non-selected hart
        bus.hart_en = 8'hFF;
        slot("s3", 1, 32'd8);
        slot("s3", 2, 32'd16);   // hart 2 resumes where it was left
        redir(1'b1, 3, 32'h100);
        slot("s3byp", 3, 32'h100);
        redir(1'b0, 0, 32'h0);
        slot("s3", 4, 32'd8);  slot("s3", 5, 32'd20); slot("s3", 6, 32'd8);
        slot("s3", 7, 32'd8);  slot("s3", 0, 32'd24); slot("s3", 1, 32'd12);
        slot("s3", 2, 32'd20);
        slot("s3nxt", 3, 32'h104);
        redir(1'b1, 6, 32'h300);
        slot("s3", 4, 32'd12);
        redir(1'b0, 0, 32'h0);
        slot("s3", 5, 32'd24);
        slot("s3far", 6, 32'h300);
        slot("s3", 7, 32'd12); slot("s3", 0, 32'd28);

        // hart 1 moved to 0x20 and given IRQ vector 0x80 while not selected
        slot("s4", 1, 32'd16);
        redir(1'b1, 1, 32'h20);
        irq(1, 32'h80);
        slot("s4", 2, 32'd24);
        redir(1'b0, 0, 32'h0);
        irq_off();
        slot("s4", 3, 32'h108); slot("s4", 4, 32'd16); slot("s4", 5, 32'd28);
        slot("s4", 6, 32'h304); slot("s4", 7, 32'd16); slot("s4", 0, 32'd32);
        slot("s4irq", 1, 32'h80, 1'b1, 32'h20);
        slot("s4", 2, 32'd28);  slot("s4", 3, 32'h10c); slot("s4", 4, 32'd20);
        slot("s4", 5, 32'd32);  slot("s4", 6, 32'h308); slot("s4", 7, 32'd20);
        slot("s4", 0, 32'd36);
        slot("s4ret", 1, 32'h84);

        // redirect and pending IRQ on the same hart in the same slot
        bus.hart_en = 8'h03;
        irq(1, 32'h80);
        slot("s5", 0, 32'd40);
        irq_off();
        redir(1'b1, 1, 32'h200);
        slot("s5both", 1, 32'h80, 1'b1, 32'h200);
        redir(1'b0, 0, 32'h0);
        slot("s5", 0, 32'd44);
        slot("s5", 1, 32'h84);

        // IRQ pulse for the hart being issued is deferred to its next slot
        irq(0, 32'h40);
        slot("dfr", 0, 32'd48);
        irq_off();
        slot("dfr", 1, 32'h88);
        slot("dfrirq", 0, 32'h40, 1'b1, 32'd52);

        // stall for 3 cycles, IRQ captured meanwhile
        bus.stall = 1'b1;
        irq(1, 32'hC0);
        slot("stall", 0, 32'h40, 1'b1, 32'd52);
        irq_off();
        slot("stall", 0, 32'h40, 1'b1, 32'd52);
        slot("stall", 0, 32'h40, 1'b1, 32'd52);
        bus.stall = 1'b0;
        slot("stlirq", 1, 32'hC0, 1'b1, 32'h8c);
        slot("stl", 0, 32'h44);
        slot("stl", 1, 32'hC4);

        // no enabled hart; an IRQ for hart 2 is left pending
        bus.hart_en = 8'h00;
        irq(2, 32'h90);
        tick();
        outs("noen", 1'b0, 0, 32'h0, 1'b0, 32'h0);
        irq_off();
        tick();
        outs("noen", 1'b0, 0, 32'h0, 1'b0, 32'h0);
        bus.hart_en = 8'h03;
        slot("reen", 0, 32'h48);

        // asynchronous reset mid-cycle, pending IRQ discarded
        #2 rst = 1'b1;
        #1 outs("arst", 1'b0, 0, 32'h0, 1'b0, 32'h0);
        bus.hart_en = 8'hFF;
        #2 rst = 1'b0;
        for (int k = 0; k < 8; k++) slot("rstrt", k, 32'h0);
        slot("rstrt", 0, 32'h4);
        slot("rstrt", 1, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
